// File: rtl/pe_conv_pool_stream_pkg.sv
// Shared constants and geometry helpers for the streaming conv/pool PE column.
package pe_conv_pool_stream_pkg;
  localparam int KTAPS = 9;

  function automatic int out_rows(input int img_row);
    return img_row - 2;
  endfunction

  function automatic int pool_rows(input int img_row);
    return (img_row - 2) / 2;
  endfunction
endpackage

// File: rtl/pe_conv_pool_stream_if.sv
// Column stream in (one channel of one image column per beat), pooled column stream out.
interface pe_conv_pool_stream_if import pe_conv_pool_stream_pkg::*; #(
  parameter int IMG_ROW = 13,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20
);
  localparam int POOL_ROW = pool_rows(IMG_ROW);

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_sof;
  logic [IMG_ROW*DATA_W-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [POOL_ROW*ACC_W-1:0] out_data;

  modport master (output in_valid, in_sof, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_sof, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/pe_conv_pool_stream_mac.sv
// Combinational 3x3 dot products of one channel over a three-column window, one lane per conv row.
module pe_conv_pool_stream_mac import pe_conv_pool_stream_pkg::*; #(
  parameter int IMG_ROW = 13,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20
) (
  input  logic [IMG_ROW-1:0][DATA_W-1:0]          col_l,
  input  logic [IMG_ROW-1:0][DATA_W-1:0]          col_m,
  input  logic [IMG_ROW-1:0][DATA_W-1:0]          col_r,
  input  logic [KTAPS-1:0][DATA_W-1:0]            kern,
  output logic [out_rows(IMG_ROW)-1:0][ACC_W-1:0] sums
);
  localparam int OUT_ROW = out_rows(IMG_ROW);

  logic [2:0][IMG_ROW-1:0][DATA_W-1:0] cols;
  assign cols = {col_r, col_m, col_l};

  for (genvar i = 0; i < OUT_ROW; i++) begin : g_row
    always_comb begin
      logic signed [ACC_W-1:0] sum, px, wk;
      sum = '0;
      px  = '0;
      wk  = '0;
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          // pixels are unsigned: zero-extend before the signed multiply
          px  = ACC_W'($signed({1'b0, cols[k][i+r]}));
          wk  = ACC_W'($signed(kern[r*3+k]));
          sum = sum + px * wk;
        end
      end
      sums[i] = sum;
    end
  end
endmodule

// File: rtl/pe_conv_pool_stream.sv
// Streaming 3x3 conv column with multi-channel accumulation, optional ReLU and 2x2/stride-2 max pool.
module pe_conv_pool_stream import pe_conv_pool_stream_pkg::*; #(
  parameter int IMG_ROW = 13,
  parameter int DATA_W  = 8,
  parameter int MAX_CH  = 4,
  parameter int ACC_W   = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(MAX_CH+1)-1:0] cfg_ch,
  input  logic                        cfg_relu,
  input  logic                        w_we,
  input  logic [$clog2(MAX_CH)-1:0]   w_ch,
  input  logic [KTAPS*DATA_W-1:0]     w_data,
  pe_conv_pool_stream_if.slave        s
);
  localparam int OUT_ROW  = out_rows(IMG_ROW);
  localparam int POOL_ROW = pool_rows(IMG_ROW);
  localparam int CH_W     = $clog2(MAX_CH+1);
  localparam int CHI_W    = $clog2(MAX_CH);
  localparam int IW       = $clog2(2*MAX_CH);
  localparam int COL_W    = IMG_ROW*DATA_W;

  logic [COL_W-1:0]              sr [2*MAX_CH];
  logic [KTAPS*DATA_W-1:0]       wts [MAX_CH];
  logic [CH_W-1:0]               nch, c_cfg, c_eff;
  logic [CHI_W-1:0]              ch, ch_eff;
  logic                          relu, relu_eff;
  logic [1:0]                    col, col_eff;
  logic                          k_odd, k_eff, last, accept;
  logic [COL_W-1:0]              tap1, tap2;
  logic [OUT_ROW-1:0][ACC_W-1:0] acc, acc_nxt, mac, conv;
  logic [POOL_ROW-1:0][ACC_W-1:0] hold, vmax, pooled;

  function automatic logic [ACC_W-1:0] smax(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign s.in_ready = !s.out_valid | s.out_ready;
  assign accept     = s.in_valid & s.in_ready;

  // An in_sof beat behaves as column 0 / channel 0 with freshly sampled config.
  always_comb begin
    c_cfg    = (cfg_ch == '0) ? CH_W'(1) : (cfg_ch > CH_W'(MAX_CH)) ? CH_W'(MAX_CH) : cfg_ch;
    c_eff    = s.in_sof ? c_cfg : nch;
    relu_eff = s.in_sof ? cfg_relu : relu;
    ch_eff   = s.in_sof ? '0 : ch;
    col_eff  = s.in_sof ? '0 : col;
    k_eff    = s.in_sof ? 1'b0 : k_odd;
    last     = (ch_eff == CHI_W'(c_eff - 1'b1));
    tap1     = sr[IW'(c_eff - 1'b1)];
    tap2     = sr[IW'({c_eff, 1'b0} - 1'b1)];
  end

  pe_conv_pool_stream_mac #(
    .IMG_ROW (IMG_ROW),
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W)
  ) u_mac (
    .col_l (tap2),
    .col_m (tap1),
    .col_r (s.in_data),
    .kern  (wts[ch_eff]),
    .sums  (mac)
  );

  always_comb begin
    acc_nxt = '0;
    conv    = '0;
    vmax    = '0;
    pooled  = '0;
    for (int i = 0; i < OUT_ROW; i++) begin
      acc_nxt[i] = ((ch_eff == '0) ? '0 : acc[i]) + mac[i];
      conv[i]    = (relu_eff && acc_nxt[i][ACC_W-1]) ? '0 : acc_nxt[i];
    end
    // an odd trailing conv row has no partner and is dropped
    for (int p = 0; p < POOL_ROW; p++) begin
      vmax[p]   = smax(conv[2*p], conv[2*p+1]);
      pooled[p] = smax(hold[p], vmax[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr          <= '{default: '0};
      wts         <= '{default: '0};
      nch         <= '0;
      ch          <= '0;
      relu        <= 1'b0;
      col         <= '0;
      k_odd       <= 1'b0;
      acc         <= '0;
      hold        <= '0;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
    end else begin
      if (w_we && (int'(w_ch) < MAX_CH)) wts[w_ch] <= w_data;
      if (s.out_ready) s.out_valid <= 1'b0;
      if (accept) begin
        sr[0] <= s.in_data;
        for (int i = 1; i < 2*MAX_CH; i++) sr[i] <= sr[i-1];
        acc   <= acc_nxt;
        nch   <= c_eff;
        relu  <= relu_eff;
        ch    <= last ? '0 : ch_eff + 1'b1;
        col   <= col_eff;
        k_odd <= k_eff;
        if (s.in_sof) hold <= '0;
        if (last) begin
          if (col_eff != 2'd2) begin
            col <= col_eff + 2'd1;
          end else begin
            // col saturates at 2; from there each completed column is a conv column
            k_odd <= ~k_eff;
            if (!k_eff) begin
              hold <= vmax;
            end else begin
              s.out_data  <= pooled;
              s.out_valid <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule
